axil_lite_master: RTL and testbench

//  AXI4-Lite master issuing single-beat read/write transactions from a simple valid/ready command port.

---
 rtl/axil_pkg.sv | 25 ++
 rtl/axil_lite_master_if.sv | 35 +++
 rtl/axil_lite_master_phase_timer.sv | 47 ++++
 rtl/axil_lite_master.sv | 192 +++++++++++++++++++
 tb/tb_axil_lite_master.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/axil_pkg.sv
// Shared types for the AXI4-Lite master: response codes, FSM states, phase helper.
package axil_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    RSP     = 3'd5
  } axil_mst_state_t;

  // States in which the master is waiting on the AXI slave (timed by the phase timer).
  function automatic logic is_wait_phase(input axil_mst_state_t s);
    return (s == WR_REQ) || (s == WR_RESP) || (s == RD_REQ) || (s == RD_RESP);
  endfunction

endpackage

// File: rtl/axil_lite_master_if.sv
// AXI4-Lite bus bundle (five channels) with master and slave views.
interface axil_lite_master_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();

  logic [AW-1:0]   awaddr;
  logic            awvalid;
  logic            awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wvalid;
  logic            wready;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
  logic [AW-1:0]   araddr;
  logic            arvalid;
  logic            arready;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rvalid;
  logic            rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axil_lite_master_phase_timer.sv
// Saturating wait-cycle counter; flags the cycle in which LIMIT wait cycles are reached.
module axil_phase_timer #(
  parameter int unsigned LIMIT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  generate
    if (LIMIT == 0) begin : g_off
      // A zero limit turns the watchdog off entirely.
      assign expired = 1'b0;
    end else begin : g_on
      localparam int CW = $clog2(LIMIT + 1);
      localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_d;

      // Count wait cycles, restart on phase change, hold at the last value (no wrap).
      always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
          cnt_d = '0;
        end else if (enable && (cnt_q != LAST)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // Counter register.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      // The LIMIT-th waiting cycle is the one with cnt_q at LAST.
      assign expired = enable && (cnt_q == LAST);
    end
  endgenerate

endmodule

// File: rtl/axil_lite_master.sv
// AXI4-Lite master: one single-beat read or write in flight, command in / response out.
module axil_lite_master
  import axil_pkg::*;
#(
  parameter int          C_M_AXI_ADDR_WIDTH = 32,
  parameter int          C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_TIMEOUT_CYCLES   = 1024
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESETN,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic                              rsp_write,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                        rsp_resp,
  output logic                              busy,
  output logic                              timeout_err,
  axil_lite_master_if.master                m_axi
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int SW = DW / 8;

  axil_mst_state_t state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [SW-1:0]   wstrb_q, wstrb_d;
  logic            awvalid_q, awvalid_d;
  logic            wvalid_q, wvalid_d;
  logic            bready_q, bready_d;
  logic            arvalid_q, arvalid_d;
  logic            rready_q, rready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_write_q, rsp_write_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  axi_resp_t       rsp_resp_q, rsp_resp_d;
  logic            busy_q, busy_d;
  logic            timeout_err_q, timeout_err_d;
  logic            phase_expired;

  // Next state and next values of every registered output.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    bready_d      = bready_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_write_d   = rsp_write_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          wstrb_d = cmd_wstrb;
          if (cmd_write) begin
            state_d   = WR_REQ;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RD_REQ;
            arvalid_d = 1'b1;
          end
        end
      end
      WR_REQ: begin
        // AW and W complete independently; move on once neither is pending.
        awvalid_d = awvalid_q && !m_axi.awready;
        wvalid_d  = wvalid_q && !m_axi.wready;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = WR_RESP;
          bready_d = 1'b1;
        end
      end
      WR_RESP: begin
        if (m_axi.bvalid) begin
          state_d     = RSP;
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = axi_resp_t'(m_axi.bresp);
        end
      end
      RD_REQ: begin
        if (m_axi.arready) begin
          state_d   = RD_RESP;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      RD_RESP: begin
        if (m_axi.rvalid) begin
          state_d     = RSP;
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b0;
          rsp_rdata_d = m_axi.rdata;
          rsp_resp_d  = axi_resp_t'(m_axi.rresp);
        end
      end
      RSP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d        = (state_d != IDLE);
    timeout_err_d = timeout_err_q | phase_expired;
  end

  // State and output registers; reset may arrive in any state.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_write_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= OKAY;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      bready_q      <= bready_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_write_q   <= rsp_write_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Timer restarts whenever the FSM changes state; it only runs while waiting on the slave.
  axil_phase_timer #(
    .LIMIT (C_TIMEOUT_CYCLES)
  ) u_phase_timer (
    .clk     (S_AXI_ACLK),
    .rst_n   (S_AXI_ARESETN),
    .clear   (state_d != state_q),
    .enable  (is_wait_phase(state_q)),
    .expired (phase_expired)
  );

  assign cmd_ready     = (state_q == IDLE);
  assign rsp_valid     = rsp_valid_q;
  assign rsp_write     = rsp_write_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign busy          = busy_q;
  assign timeout_err   = timeout_err_q;
  assign m_axi.awaddr  = addr_q;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = wstrb_q;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;
  assign m_axi.araddr  = addr_q;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = rready_q;

endmodule

// File: tb/tb_axil_lite_master.sv
// Bench: randomized commands against a responder with programmable per-channel delays,
// expectations from a word-array reference model and latency arithmetic.
`timescale 1ns/1ps
module tb_axil_lite_master;
  import axil_pkg::*;

  localparam int TO = 16;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        busy, timeout_err;

  axil_lite_master_if #(.AW(32), .DW(32)) bus ();

  axil_lite_master #(
    .C_M_AXI_ADDR_WIDTH (32),
    .C_M_AXI_DATA_WIDTH (32),
    .C_TIMEOUT_CYCLES   (TO)
  ) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_write     (cmd_write),
    .cmd_addr      (cmd_addr),
    .cmd_wdata     (cmd_wdata),
    .cmd_wstrb     (cmd_wstrb),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_write     (rsp_write),
    .rsp_rdata     (rsp_rdata),
    .rsp_resp      (rsp_resp),
    .busy          (busy),
    .timeout_err   (timeout_err),
    .m_axi         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int txn_no = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Responder state (programmed per transaction by the stimulus task).
  int          aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
  logic [1:0]  inj_resp = 2'b00;
  int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  int          aw_hi = 0, w_hi = 0, ar_hi = 0, b_hs = 0, r_hs = 0;
  logic [31:0] aw_addr_log = 0, w_data_log = 0, ar_addr_log = 0;
  logic [3:0]  w_strb_log = 0;
  logic [31:0] slv_mem [16];
  logic [7:0]  tx_byte = 8'h00;
  logic [31:0] ref_mem [16];

  // Slave: readies/valids are decided at the falling edge for the next rising edge.
  initial begin : responder
    bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = 0;
    bus.arready = 0; bus.rvalid = 0; bus.rresp = 0; bus.rdata = 0;
    forever begin
      @(negedge clk);
      if (bus.awvalid) aw_hi++;
      if (bus.wvalid)  w_hi++;
      if (bus.arvalid) ar_hi++;
      if (bus.awvalid) begin
        if (aw_cnt < aw_delay) begin bus.awready = 0; aw_cnt++; end
        else begin bus.awready = 1; aw_addr_log = bus.awaddr; end
      end else begin bus.awready = 0; aw_cnt = 0; end
      if (bus.wvalid) begin
        if (w_cnt < w_delay) begin bus.wready = 0; w_cnt++; end
        else begin bus.wready = 1; w_data_log = bus.wdata; w_strb_log = bus.wstrb; end
      end else begin bus.wready = 0; w_cnt = 0; end
      if (bus.bready) begin
        if (b_cnt < b_delay) begin bus.bvalid = 0; b_cnt++; end
        else begin
          bus.bvalid = 1; bus.bresp = inj_resp;
          if (inj_resp == OKAY) begin
            for (int b = 0; b < 4; b++)
              if (w_strb_log[b]) slv_mem[aw_addr_log[5:2]][8*b +: 8] = w_data_log[8*b +: 8];
            if (aw_addr_log[5:2] == 4'd1 && w_strb_log[0]) tx_byte = w_data_log[7:0];
          end
        end
      end else begin bus.bvalid = 0; bus.bresp = 0; b_cnt = 0; end
      if (bus.arvalid) begin
        if (ar_cnt < ar_delay) begin bus.arready = 0; ar_cnt++; end
        else begin bus.arready = 1; ar_addr_log = bus.araddr; end
      end else begin bus.arready = 0; ar_cnt = 0; end
      if (bus.rready) begin
        if (r_cnt < r_delay) begin bus.rvalid = 0; r_cnt++; end
        else begin
          bus.rvalid = 1; bus.rresp = inj_resp;
          bus.rdata  = (inj_resp == OKAY) ? slv_mem[ar_addr_log[5:2]] : 32'hDEADBEEF;
        end
      end else begin bus.rvalid = 0; bus.rresp = 0; bus.rdata = 0; r_cnt = 0; end
      if (bus.bvalid && bus.bready) b_hs++;
      if (bus.rvalid && bus.rready) r_hs++;
    end
  end

  // One complete command/response exchange. For reads d_a is the AR delay and d_b the R delay.
  task automatic do_txn(input bit wr, input logic [3:0] idx, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [1:0] resp,
                        input int d_a, input int d_w, input int d_b, input int hold,
                        output int first_to, output logic to_arvalid);
    logic [31:0] addr;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          lat;
    int          cyc;
    addr = {26'd0, idx, 2'b00};
    inj_resp = resp;
    aw_hi = 0; w_hi = 0; ar_hi = 0; b_hs = 0; r_hs = 0;
    if (wr) begin
      aw_delay = d_a; w_delay = d_w; b_delay = d_b; ar_delay = 0; r_delay = 0;
      exp_lat   = 3 + ((d_a > d_w) ? d_a : d_w) + d_b;
      exp_rdata = 32'd0;
      if (resp == OKAY)
        for (int b = 0; b < 4; b++)
          if (strb[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
    end else begin
      ar_delay = d_a; r_delay = d_b; aw_delay = 0; w_delay = 0; b_delay = 0;
      exp_lat   = 3 + d_a + d_b;
      exp_rdata = (resp == OKAY) ? ref_mem[idx] : 32'hDEADBEEF;
    end
    @(negedge clk);
    cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = strb;
    cyc = 0;
    while (!cmd_ready && cyc < 50) begin @(negedge clk); cyc++; end
    chk("cmd_ready", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 0; cmd_wdata = $urandom; cmd_addr = $urandom;
    chk("busy_after_accept", {busy, cmd_ready}, 2'b10);
    lat = 1; first_to = 0; to_arvalid = 0;
    while (1) begin
      if (timeout_err && first_to == 0) begin first_to = lat; to_arvalid = bus.arvalid; end
      if (rsp_valid || lat >= 200) break;
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, exp_lat);
    repeat (hold) @(negedge clk);
    chk("stall_quiet", {cmd_ready, bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}, 6'b0);
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_write", rsp_write, wr);
    chk("rsp_resp", rsp_resp, resp);
    chk("rsp_rdata", rsp_rdata, exp_rdata);
    if (wr) begin
      chk("awaddr", aw_addr_log, addr);
      chk("wdata", w_data_log, wdata);
      chk("wstrb", w_strb_log, strb);
      chk("aw_cycles", aw_hi, d_a + 1);
      chk("w_cycles", w_hi, d_w + 1);
      chk("b_handshakes", b_hs, 1);
    end else begin
      chk("araddr", ar_addr_log, addr);
      chk("ar_cycles", ar_hi, d_a + 1);
      chk("r_handshakes", r_hs, 1);
    end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    chk("rsp_consumed", {rsp_valid, busy, cmd_ready}, 3'b001);
    txn_no++;
    $display("txn %0d %s addr=%h wdata=%h strb=%h resp=%0d lat=%0d/%0d rdata=%h",
             txn_no, wr ? "WR" : "RD", addr, wdata, strb, resp, lat, exp_lat, rsp_rdata);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int          fto;
    logic        tav;
    int          cyc;
    bit          wr;
    logic [1:0]  rr;
    rst_n = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
    rsp_ready = 0;
    for (int i = 0; i < 16; i++) begin
      slv_mem[i] = 32'h5A000000 | (i * 32'h00010203);
      ref_mem[i] = 32'h5A000000 | (i * 32'h00010203);
    end
    slv_mem[0] = 32'h0000003C;
    ref_mem[0] = 32'h0000003C;

    repeat (3) @(negedge clk);
    chk("reset_outputs", {busy, rsp_valid, timeout_err, bus.awvalid, bus.wvalid,
                          bus.bready, bus.arvalid, bus.rready}, 8'h00);
    chk("reset_rdata", rsp_rdata, 32'h0);
    rst_n = 1;
    @(negedge clk);
    chk("cmd_ready_after_reset", cmd_ready, 1);

    // UART TX data write, everything ready immediately.
    do_txn(1, 4'd1, 32'h000000A5, 4'hF, OKAY, 0, 0, 0, 0, fto, tav);
    chk("tx_byte", tx_byte, 8'hA5);
    // UART RX data read.
    do_txn(0, 4'd0, 32'h0, 4'h0, OKAY, 0, 0, 0, 1, fto, tav);
    chk("rx_byte", rsp_rdata[7:0], 8'h3C);
    // AW accepted at once, W three cycles late.
    do_txn(1, 4'd5, 32'hCAFEF00D, 4'hF, OKAY, 0, 3, 0, 0, fto, tav);
    // W before AW, slow B, response stalled.
    do_txn(1, 4'd6, 32'h12345678, 4'h6, OKAY, 4, 1, 2, 3, fto, tav);
    // Read with slave error.
    do_txn(0, 4'd6, 32'h0, 4'h0, SLVERR, 1, 0, 2, 0, fto, tav);
    chk("slverr_code", rsp_resp, 2'b10);

    for (int n = 0; n < 40; n++) begin
      wr = 1'($urandom_range(0, 1));
      rr = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      do_txn(wr, 4'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)), rr,
             $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
             $urandom_range(0, 3), fto, tav);
    end
    chk("no_timeout_yet", timeout_err, 0);

    // ARREADY withheld past the timeout: flag rises while ARVALID is still up, read completes.
    do_txn(0, 4'd7, 32'h0, 4'h0, OKAY, 20, 0, 0, 0, fto, tav);
    chk("timeout_window", (fto >= TO) && (fto <= TO + 1), 1);
    chk("timeout_arvalid", tav, 1);
    chk("timeout_sticky", timeout_err, 1);

    // Reset asserted while waiting for B.
    aw_delay = 0; w_delay = 0; b_delay = 30; inj_resp = OKAY;
    @(negedge clk);
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h8; cmd_wdata = 32'h11223344; cmd_wstrb = 4'hF;
    @(negedge clk);
    cmd_valid = 0;
    cyc = 0;
    while (!bus.bready && cyc < 20) begin @(negedge clk); cyc++; end
    chk("reached_wr_resp", bus.bready, 1);
    #2 rst_n = 0;
    #1;
    chk("async_reset", {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready,
                        rsp_valid, busy, timeout_err}, 8'h00);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("ready_after_midreset", {cmd_ready, busy}, 2'b10);
    do_txn(0, 4'd2, 32'h0, 4'h0, OKAY, 1, 0, 1, 0, fto, tav);
    do_txn(1, 4'd2, 32'h0BADF00D, 4'hF, OKAY, 0, 0, 0, 0, fto, tav);
    do_txn(0, 4'd2, 32'h0, 4'h0, OKAY, 0, 0, 0, 0, fto, tav);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
